// File: rtl/vend_machine.sv
// Newspaper vending controller: Moore FSM summing nickels and dimes to 15.
// Dispenses for one cycle on reaching 15; overpayment is not returned.
module vend_machine (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin,
  output logic       newspaper,
  output logic [1:0] credit
);

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10,
    S15 = 2'b11
  } state_t;

  state_t state;
  state_t state_nx;
  logic   nickel;
  logic   dime;

  always_comb begin
    nickel = 1'b0;
    dime   = 1'b0;
    unique case (1'b1)
      (coin == 2'b01): nickel = 1'b1;
      (coin == 2'b10): dime   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S0;
    end else begin
      state <= state_nx;
    end
  end

  // A coin arriving in S15 is dropped; the sale always returns to S0.
  always_comb begin
    state_nx = state;
    case (state)
      S0: begin
        if (nickel) state_nx = S5;
        else if (dime) state_nx = S10;
      end
      S5: begin
        if (nickel) state_nx = S10;
        else if (dime) state_nx = S15;
      end
      S10: begin
        if (nickel || dime) state_nx = S15;
      end
      S15: state_nx = S0;
      default: state_nx = S0;
    endcase
  end

  assign newspaper = (state == S15);
  assign credit    = state;

endmodule

// File: tb/tb_vend_machine.sv
// Randomized scoreboard bench for vend_machine against a running-total model.
// Each issued coin queues the expected response checked after the next edge.
module tb_vend_machine;

  logic       clock;
  logic       reset;
  logic [1:0] coin;
  logic       newspaper;
  logic [1:0] credit;

  typedef struct {
    logic [1:0] credit;
    logic       np;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   amt      = 0;

  vend_machine dut (
    .clock(clock),
    .reset(reset),
    .coin(coin),
    .newspaper(newspaper),
    .credit(credit)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic exp_t model_out(input int a);
    exp_t e;
    e.np     = (a >= 15);
    e.credit = (a >= 15) ? 2'd3 : 2'(a / 5);
    return e;
  endfunction

  task automatic drive(input logic [1:0] c);
    int v;
    @(negedge clock);
    coin = c;
    v = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
    if (amt >= 15) amt = 0;
    else amt = amt + v;
    if (amt > 15) amt = 15;
    exp_q.push_back(model_out(amt));
  endtask

  task automatic direct_check(input string name,
                              input logic [1:0] ec,
                              input logic en);
    checks++;
    if (credit !== ec || newspaper !== en) begin
      failures++;
      $display("FAIL %s: credit=%b newspaper=%b required credit=%b newspaper=%b",
               name, credit, newspaper, ec, en);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (credit !== e.credit || newspaper !== e.np) begin
        failures++;
        $display("FAIL scoreboard t=%0t: credit=%b newspaper=%b required credit=%b newspaper=%b",
                 $time, credit, newspaper, e.credit, e.np);
      end
    end
  end

  initial begin
    reset = 1'b0;
    coin  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      coin = (i % 2 == 0) ? 2'b01 : 2'b00;
      #2;
      direct_check("reset_hold", 2'b00, 1'b0);
    end
    @(negedge clock);
    coin  = 2'b00;
    reset = 1'b1;
    amt   = 0;
    drive(2'b00);
    drive(2'b00);

    for (int k = 0; k < 3; k++) begin
      drive(2'b01);
      drive(2'b00);
      drive(2'b00);
    end

    drive(2'b01); drive(2'b10); drive(2'b00); drive(2'b00);
    drive(2'b10); drive(2'b10); drive(2'b00); drive(2'b00);
    drive(2'b10); drive(2'b01); drive(2'b00); drive(2'b00);

    drive(2'b01);
    drive(2'b11); drive(2'b11); drive(2'b11);
    drive(2'b00);
    drive(2'b10); drive(2'b00); drive(2'b00);

    drive(2'b10); drive(2'b01); drive(2'b01); drive(2'b01);
    drive(2'b00);
    drive(2'b10); drive(2'b00);

    drive(2'b10);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    direct_check("async_reset_mid", 2'b00, 1'b0);
    reset = 1'b1;
    amt   = 0;
    drive(2'b00);

    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)));
    end

    drive(2'b00);
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
